store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Parametrised, sequenced successor to the combinational store-size formatter.
- Performs sub-word stores (byte/halfword) to a word-wide data memory by read-modify-write: reads the containing word, merges the store data into the lane selected by the address low bits, then writes the word back.
- Full-word stores bypass the read. Misaligned halfword stores are flagged and suppressed.
- Sits between the CPU control unit (start/done handshake) and the data memory port.

Parameters:
- DATA_W, 32, memory word width in bits; legal values are 32 and 64.
- ADDR_W, 32, byte address width.
- MEM_LAT, 1, cycles from a mem_rd cycle to valid mem_rdata; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- addr  in  ADDR_W  byte address of the store.
- wdata_b  in  DATA_W  store data from register B, right-aligned.
- size_ctrl  in  2  2'b01 = halfword, 2'b10 = byte, any other value = word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the operation completes.
- misalign  out  1  valid with done; set when a halfword store has addr[0]=1.
- mem_addr  out  ADDR_W  word-aligned address: addr with the low log2(DATA_W/8) bits cleared.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  merged write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE; all outputs are 0; internal latches (address, data, size, lat counter, merge buffer) are 0. Asserting reset mid-operation aborts it with no mem_wr issued after reset asserts, and no done.
- When start=1 in IDLE, latch addr, wdata_b and size_ctrl. Inputs are don't-care afterwards. start outside IDLE is ignored, with no queuing.
- Lane index: L = latched addr[log2(DATA_W/8)-1:0].
- FSM states: IDLE, RD_REQ, RD_WAIT, WR, FIN.
- IDLE transitions on start:
  - Word store: go to WR.
  - Halfword store with addr[0]=1: go to FIN with misalign set.
  - Byte store, or aligned halfword store: go to RD_REQ.
- RD_REQ: mem_rd=1 and mem_addr driven for exactly 1 cycle. Lat counter loads 1. Next state is RD_WAIT.
- RD_WAIT: counter increments each cycle. In the cycle where the counter equals MEM_LAT, capture mem_rdata into the merge buffer and go to WR. RD_WAIT lasts exactly MEM_LAT cycles.
- Merge, performed when entering WR:
  - Byte: buffer bits [8L+7:8L] are replaced by wdata_b[7:0]; all other bits come from mem_rdata.
  - Halfword: buffer bits [8L+15:8L] are replaced by wdata_b[15:0]; L is even.
  - Word: the buffer equals wdata_b; no read is performed.
- WR: mem_wr=1 and mem_wdata = buffer for 1 cycle. mem_addr stays valid. Next state is FIN.
- FIN: done=1 for 1 cycle. misalign=1 only on the misalign path. Next state is IDLE. busy is 1 in FIN.
- Misalign path: no mem_rd and no mem_wr are ever asserted.
- mem_addr is held stable from RD_REQ (or WR) through FIN, and is 0 in IDLE.
- mem_wdata is 0 outside WR. mem_rd, mem_wr and done are never asserted simultaneously.
- Latency from the start cycle (cycle 0) to the done cycle:
  - Word: 2 cycles.
  - Byte or aligned halfword: 3 + MEM_LAT cycles.
  - Misalign: 1 cycle.
- Back-to-back operation: a new start is accepted in the IDLE cycle following FIN. There is no overlap between operations.

Test Plan:
1. Word store, DATA_W=32: addr=0x1002, wdata_b=0xDEADBEEF, size=00 -> cycle 1: mem_wr=1, mem_addr=0x1000, mem_wdata=0xDEADBEEF; cycle 2: done=1; mem_rd never asserted.
2. Byte store, all four lanes, MEM_LAT=1, mem_rdata=0x11223344, wdata_b=0xAB:
   - addr=0x…0 -> mem_wdata 0x112233AB
   - addr=0x…1 -> mem_wdata 0x1122AB44
   - addr=0x…2 -> mem_wdata 0x11AB3344
   - addr=0x…3 -> mem_wdata 0xAB223344
   - In every case done occurs at cycle 4.
3. Halfword store, MEM_LAT=3: addr=0x2002, wdata_b=0xFFFFCAFE, mem_rdata=0x55667788 -> mem_rd at cycle 1; rdata sampled at cycle 4; mem_wr at cycle 5 with 0xCAFE7788; done at cycle 6.
4. Misaligned halfword store: addr=0x3001, size=01 -> done=1 and misalign=1 at cycle 1; mem_rd and mem_wr stay 0 throughout.
5. Protocol checks:
   - start held high during a byte operation -> exactly one operation is performed.
   - rst_n pulsed low during RD_WAIT -> all outputs 0 immediately; no mem_wr and no done follow; a new start after reset completes normally.
6. DATA_W=64, byte store: addr=0x…5, mem_rdata=0x0011223344556677, wdata_b=0x9A -> mem_wdata=0x00119A3344556677; mem_addr has its low 3 bits cleared.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit: sequenced read-modify-write engine for sub-word stores.
// Byte and halfword stores read the containing memory word, merge the store
// data into the lane picked by the low address bits and write the word back.
// Full-word stores skip the read. Misaligned halfword stores are reported
// through misalign and never touch memory.
module store_merge_unit #(
    parameter int DATA_W  = 32,   // 32 or 64
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1     // mem_rd cycle to valid mem_rdata, >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [1:0]        size_ctrl,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int CNT_W  = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        FIN
    } state_t;

    state_t state;

    // Operation context captured at start. Only the lane bits of the address
    // and the low 16 data bits are needed after the start cycle: the aligned
    // address lives in mem_addr and word stores load mem_wdata directly.
    logic [OFF_W-1:0] lane;
    logic [15:0]      wdata_q;
    logic [1:0]       size_q;
    logic [CNT_W-1:0] lat_cnt;

    // Merge datapath
    logic [NBYTES-1:0] byte_en;
    logic [DATA_W-1:0] ins_data;
    logic [DATA_W-1:0] merged;

    // Start-cycle decode
    logic              start_word;
    logic              start_mis;
    logic [ADDR_W-1:0] addr_aligned;

    assign start_word   = (size_ctrl != SZ_HALF) && (size_ctrl != SZ_BYTE);
    assign start_mis    = (size_ctrl == SZ_HALF) && addr[0];
    assign addr_aligned = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Lane enables and replicated store data for the sub-word merge.
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        byte_en  = '0;
        ins_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (size_q == SZ_BYTE) begin
                byte_en[i]         = (lane == OFF_W'(i));
                ins_data[8*i +: 8] = wdata_q[7:0];
            end else begin
                // Halfword: lane is even, so the pair {lane, lane+1} shares lane[OFF_W-1:1].
                byte_en[i]         = (lane[OFF_W-1:1] == (OFF_W-1)'(i / 2));
                ins_data[8*i +: 8] = (i % 2 == 1) ? wdata_q[15:8] : wdata_q[7:0];
            end
        end
    end

    // Byte-wise select between returned memory data and store data.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = ins_data[8*i +: 8];
            end
        end
    end

    // Control FSM with registered outputs; mem_wdata doubles as the merge buffer.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, not only the FSM,
            // because an aborted operation must leave no stale address/data.
            state     <= IDLE;
            lane      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lane    <= addr[OFF_W-1:0];
                        wdata_q <= wdata_b[15:0];
                        size_q  <= size_ctrl;
                        busy    <= 1'b1;
                        if (start_word) begin
                            state     <= WR;
                            mem_addr  <= addr_aligned;
                            mem_wr    <= 1'b1;
                            mem_wdata <= wdata_b;
                        end else if (start_mis) begin
                            state    <= FIN;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state    <= RD_REQ;
                            mem_addr <= addr_aligned;
                            mem_rd   <= 1'b1;
                        end
                    end
                end

                RD_REQ: begin
                    mem_rd  <= 1'b0;
                    lat_cnt <= CNT_W'(1);
                    state   <= RD_WAIT;
                end

                RD_WAIT: begin
                    // The counter counts RD_WAIT cycles; the last one carries valid read data.
                    if (lat_cnt == LAT_LAST) begin
                        mem_wdata <= merged;
                        mem_wr    <= 1'b1;
                        state     <= WR;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                WR: begin
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    done      <= 1'b1;
                    state     <= FIN;
                end

                FIN: begin
                    done     <= 1'b0;
                    misalign <= 1'b0;
                    busy     <= 1'b0;
                    mem_addr <= '0;
                    state    <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    misalign  <= 1'b0;
                    mem_addr  <= '0;
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit: three configurations (32-bit/lat 1,
// 32-bit/lat 3, 64-bit/lat 1) share a clock and reset. Stimulus pushes the
// expected outcome of each store into a scoreboard; a monitor observes the
// memory port every cycle and retires entries on done.
module tb_store_merge_unit;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        bit          mis;
        bit          has_rd;
        logic [31:0] waddr;
        logic [63:0] wdata;
        int          t0;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_bad;

    logic        start_v [NI];
    logic [31:0] addr_v  [NI];
    logic [63:0] wd_v    [NI];
    logic [1:0]  sz_v    [NI];
    logic [63:0] rdata_v [NI];

    wire [NI-1:0]        busy_w;
    wire [NI-1:0]        done_w;
    wire [NI-1:0]        mis_w;
    wire [NI-1:0]        rd_w;
    wire [NI-1:0]        wr_w;
    wire [NI-1:0][31:0]  maddr_w;
    wire [NI-1:0][63:0]  wdat_w;

    exp_t exp_q [$];

    // Memory model state
    logic [63:0] rd_word [NI];
    bit          rd_pend [NI];
    int          rd_age  [NI];

    // Monitor state
    int          nrd    [NI];
    int          nwr    [NI];
    int          rd_cyc [NI];
    int          wr_cyc [NI];
    logic [63:0] wr_dat [NI];

    function automatic int dw(input int k);
        return (k == 2) ? 64 : 32;
    endfunction

    function automatic int ml(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .addr(addr_v[0]),
        .wdata_b(wd_v[0][31:0]), .size_ctrl(sz_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .misalign(mis_w[0]),
        .mem_addr(maddr_w[0]), .mem_rd(rd_w[0]), .mem_wr(wr_w[0]),
        .mem_wdata(wdat_w[0][31:0]), .mem_rdata(rdata_v[0][31:0])
    );
    assign wdat_w[0][63:32] = '0;

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .addr(addr_v[1]),
        .wdata_b(wd_v[1][31:0]), .size_ctrl(sz_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .misalign(mis_w[1]),
        .mem_addr(maddr_w[1]), .mem_rd(rd_w[1]), .mem_wr(wr_w[1]),
        .mem_wdata(wdat_w[1][31:0]), .mem_rdata(rdata_v[1][31:0])
    );
    assign wdat_w[1][63:32] = '0;

    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .addr(addr_v[2]),
        .wdata_b(wd_v[2]), .size_ctrl(sz_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .misalign(mis_w[2]),
        .mem_addr(maddr_w[2]), .mem_rd(rd_w[2]), .mem_wr(wr_w[2]),
        .mem_wdata(wdat_w[2]), .mem_rdata(rdata_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_quiet(input int k);
        check($sformatf("quiet_ctl[%0d]", k),
              {59'd0, busy_w[k], done_w[k], mis_w[k], rd_w[k], wr_w[k]}, 64'd0);
        check($sformatf("quiet_addr[%0d]", k), {32'd0, maddr_w[k]}, 64'd0);
        check($sformatf("quiet_wdata[%0d]", k), wdat_w[k], 64'd0);
    endtask

    // Reference: the memory word seen as a byte array, store bytes overwrite lanes.
    function automatic logic [63:0] ref_merge(input int nb, input logic [63:0] old,
                                              input logic [63:0] wd, input logic [31:0] a,
                                              input logic [1:0] sz);
        logic [7:0]  b [8];
        logic [63:0] r;
        int          ln;
        ln = int'(a[2:0]) % nb;
        for (int i = 0; i < 8; i++) b[i] = old[8*i +: 8];
        if (sz == 2'b10) begin
            b[ln] = wd[7:0];
        end else if (sz == 2'b01) begin
            b[ln]     = wd[7:0];
            b[ln + 1] = wd[15:8];
        end else begin
            for (int i = 0; i < 8; i++) b[i] = wd[8*i +: 8];
        end
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Memory model: data is valid only in the cycle MEM_LAT after the mem_rd cycle.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            rdata_v[k] = {$urandom(), $urandom()};
            if (rd_pend[k]) begin
                rd_age[k]++;
                if (rd_age[k] == ml(k)) rdata_v[k] = rd_word[k];
                if (rd_age[k] >= ml(k)) rd_pend[k] = 1'b0;
            end
            if (rd_w[k]) begin
                rd_pend[k] = 1'b1;
                rd_age[k]  = 0;
            end
        end
    end

    // Monitor: per-cycle protocol checks and retirement of scoreboard entries.
    initial forever begin
        bit   have;
        exp_t e;
        int   nstrobe;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                nrd[k] = 0;
                nwr[k] = 0;
            end else if (busy_w[k] || done_w[k] || rd_w[k] || wr_w[k] || mis_w[k]) begin
                have = (exp_q.size() != 0) && (exp_q[0].inst == k);
                check($sformatf("activity_expected[%0d]", k), {63'd0, have}, 64'd1);
                if (have) begin
                    e = exp_q[0];
                    nstrobe = int'(rd_w[k]) + int'(wr_w[k]) + int'(done_w[k]);
                    check("busy_high", {63'd0, busy_w[k]}, 64'd1);
                    check("strobe_exclusive", {63'd0, nstrobe > 1}, 64'd0);
                    if (!e.mis) check("mem_addr", {32'd0, maddr_w[k]}, {32'd0, e.waddr});
                    if (!wr_w[k]) check("wdata_outside_wr", wdat_w[k], 64'd0);
                    if (!done_w[k]) check("misalign_without_done", {63'd0, mis_w[k]}, 64'd0);
                    if (rd_w[k]) begin
                        nrd[k]++;
                        rd_cyc[k] = cyc;
                    end
                    if (wr_w[k]) begin
                        nwr[k]++;
                        wr_cyc[k] = cyc;
                        wr_dat[k] = wdat_w[k];
                    end
                    if (done_w[k]) begin
                        check("done_latency", 64'(cyc - e.t0), 64'(e.lat));
                        check("misalign", {63'd0, mis_w[k]}, {63'd0, e.mis});
                        check("rd_count", 64'(nrd[k]), {63'd0, e.has_rd});
                        check("wr_count", 64'(nwr[k]), {63'd0, !e.mis});
                        if (e.has_rd && nrd[k] == 1) check("rd_cycle", 64'(rd_cyc[k] - e.t0), 64'd1);
                        if (!e.mis && nwr[k] == 1) begin
                            check("wr_cycle", 64'(wr_cyc[k] - e.t0), 64'(e.lat - 1));
                            check("wr_data", wr_dat[k], e.wdata);
                        end
                        void'(exp_q.pop_front());
                        nrd[k] = 0;
                        nwr[k] = 0;
                    end
                end
            end else begin
                check_quiet(k);
            end
        end
    end

    // Issue one store on instance k; call at (or just after) a rising edge.
    // start stays high for 1+hold cycles while addr/data wander.
    task automatic do_op(input int k, input logic [31:0] a, input logic [63:0] wd,
                         input logic [1:0] sz, input logic [63:0] old, input int hold);
        exp_t e;
        int   nb;
        nb = dw(k) / 8;
        #1;
        rd_word[k] = old;
        e.inst   = k;
        e.mis    = (sz == 2'b01) && a[0];
        e.has_rd = !e.mis && (sz == 2'b01 || sz == 2'b10);
        e.waddr  = a & ~32'(nb - 1);
        e.wdata  = e.mis ? 64'd0 : ref_merge(nb, old, wd, a, sz);
        e.t0     = cyc;
        e.lat    = e.mis ? 1 : (e.has_rd ? 3 + ml(k) : 2);
        exp_q.push_back(e);
        start_v[k] = 1'b1;
        addr_v[k]  = a;
        wd_v[k]    = wd;
        sz_v[k]    = sz;
        for (int i = 0; i <= hold; i++) begin
            @(posedge clk);
            #1;
            addr_v[k] = $urandom();
            wd_v[k]   = {$urandom(), $urandom()};
            sz_v[k]   = 2'($urandom_range(0, 3));
        end
        start_v[k] = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        check("op_timeout", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // Abort a byte store on instance 1 (MEM_LAT=3) while it sits in RD_WAIT.
    task automatic reset_mid_op();
        exp_t e;
        #1;
        rd_word[1] = 64'h0BAD_0BAD;
        e.inst = 1; e.mis = 1'b0; e.has_rd = 1'b1; e.waddr = 32'h0000_7000;
        e.wdata = 64'd0; e.t0 = cyc; e.lat = 6;
        exp_q.push_back(e);
        start_v[1] = 1'b1;
        addr_v[1]  = 32'h0000_7001;
        wd_v[1]    = 64'h77;
        sz_v[1]    = 2'b10;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        for (int k = 0; k < NI; k++) check_quiet(k);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0;
            addr_v[k]  = '0;
            wd_v[k]    = '0;
            sz_v[k]    = '0;
            rdata_v[k] = '0;
            rd_word[k] = '0;
            rd_pend[k] = 1'b0;
            rd_age[k]  = 0;
            nrd[k]     = 0;
            nwr[k]     = 0;
            rd_cyc[k]  = 0;
            wr_cyc[k]  = 0;
            wr_dat[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) check_quiet(k);
        rst_n = 1'b1;
        @(posedge clk);

        // Word store bypasses the read
        do_op(0, 32'h0000_1002, 64'hDEAD_BEEF, 2'b00, 64'h0, 0);
        // Byte store into each lane of a 32-bit word
        for (int i = 0; i < 4; i++)
            do_op(0, 32'(32'h0000_4000 + i), 64'hAB, 2'b10, 64'h1122_3344, 0);
        // Aligned halfword with MEM_LAT=3
        do_op(1, 32'h0000_2002, 64'hFFFF_CAFE, 2'b01, 64'h5566_7788, 0);
        // Misaligned halfword
        do_op(0, 32'h0000_3001, 64'h1234, 2'b01, 64'h0, 0);
        // 64-bit byte store in lane 5
        do_op(2, 32'h0000_5005, 64'h9A, 2'b10, 64'h0011_2233_4455_6677, 0);
        // start held through the whole byte operation
        do_op(0, 32'h0000_6001, 64'h5C, 2'b10, 64'hA5A5_A5A5, 3 + ml(0));
        // Reset during RD_WAIT, then a normal operation
        reset_mid_op();
        do_op(1, 32'h0000_7003, 64'h3C, 2'b10, 64'h8899_AABB, 0);
        do_op(1, 32'h0000_7005, 64'h0, 2'b11, 64'h0, 0);

        // Randomized stores on every configuration, occasionally with idle gaps
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                do_op(k, $urandom(), {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                      {$urandom(), $urandom()}, 0);
            end
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
